// File: rtl/wd_service_master_if.sv
// wd_service_master_if: watchdog ABUS/DBUS write port plus the failure status it returns
interface wd_service_master_if;
    logic [1:0] abus;
    logic [7:0] dbus;
    logic       wdfail;
    logic [1:0] flstat;
    modport master (output abus, dbus, input wdfail, flstat);
    modport slave  (input abus, dbus, output wdfail, flstat);
endinterface

// File: rtl/wd_service_master.sv
// wd_service_master: unlocks and configures the watchdog, then services it periodically or on kick
module wd_service_master #(
    parameter logic [7:0]  KEY0     = 8'h55,
    parameter logic [7:0]  KEY1     = 8'hAA,
    parameter logic [7:0]  SRV_CODE = 8'hA5,
    parameter logic [15:0] PERIOD   = 16'd100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [7:0]                 cfg_win,
    input  logic [7:0]                 cfg_rstlmt,
    input  logic                       kick,
    input  logic                       clr,
    wd_service_master_if.master        bus,
    output logic                       busy,
    output logic                       cfg_done,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [7:0]                 kick_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_UNLK0, S_UNLK1, S_WRITE, S_GAP, S_WAIT, S_FAILED} state_t;
    localparam logic [1:0] CFG0 = 2'd0, CFG1 = 2'd1, SRV = 2'd2;
    state_t      st, nxt;
    logic [1:0]  job, nj;
    logic [7:0]  wdat;
    logic [15:0] cnt;
    logic        pend, kreq, in_txn, srv_go, gap_ok;
    assign kreq   = kick | pend;
    assign in_txn = st inside {S_UNLK0, S_UNLK1, S_WRITE, S_GAP};
    assign srv_go = (nxt == S_UNLK0) && (nj == SRV);
    assign gap_ok = (st == S_GAP) && !bus.wdfail;
    always_comb begin
        nxt = st;
        nj  = job;
        case (st)
            S_IDLE:  if (en) begin
                nxt = cfg_done ? S_WAIT : S_UNLK0;
                nj  = cfg_done ? job : CFG0;
            end
            S_UNLK0: nxt = S_UNLK1;
            S_UNLK1: nxt = S_WRITE;
            S_WRITE: nxt = S_GAP;
            S_GAP: begin
                if (!en) nxt = S_IDLE;
                else if (job == CFG0) begin
                    nxt = S_UNLK0;
                    nj  = CFG1;
                end else if (kreq) begin
                    nxt = S_UNLK0;
                    nj  = SRV;
                end else nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!en) nxt = S_IDLE;
                else if (kreq || cnt == 16'd0) begin
                    nxt = S_UNLK0;
                    nj  = SRV;
                end
            end
            S_FAILED: if (clr) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (bus.wdfail) nxt = S_FAILED;
    end
    // Outputs are registered from the next state so the bus reflects the state of the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_IDLE;
            job        <= CFG0;
            wdat       <= 8'h00;
            cnt        <= 16'd0;
            pend       <= 1'b0;
            bus.abus   <= 2'b00;
            bus.dbus   <= 8'h00;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            kick_cnt   <= 8'h00;
        end else begin
            st         <= nxt;
            job        <= nj;
            bus.abus   <= (nxt == S_WRITE) ? {nj[1], |nj} : 2'b00;
            bus.dbus   <= (nxt == S_UNLK0) ? KEY0 : (nxt == S_UNLK1) ? KEY1 : (nxt == S_WRITE) ? wdat : 8'h00;
            busy       <= nxt inside {S_UNLK0, S_UNLK1, S_WRITE, S_GAP};
            fault      <= nxt == S_FAILED;
            fault_code <= (nxt != S_FAILED) ? 2'b00 : (st != S_FAILED) ? bus.flstat : fault_code;
            pend       <= (srv_go || (st == S_GAP && !en) || st == S_FAILED) ? 1'b0 : pend | (kick & in_txn);
            if (st == S_UNLK0) wdat <= (job == CFG0) ? cfg_win : (job == CFG1) ? cfg_rstlmt : SRV_CODE;
            if (nxt == S_WAIT && st != S_WAIT) cnt <= PERIOD - 16'd1;
            else if (st == S_WAIT) cnt <= cnt - 16'd1;
            if (st == S_FAILED && nxt == S_IDLE) cfg_done <= 1'b0;
            else if (gap_ok && job == CFG1) cfg_done <= 1'b1;
            if (gap_ok && job == SRV && kick_cnt != 8'hFF) kick_cnt <= kick_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wd_service_master.sv
// tb_wd_service_master: directed and random stimulus checked every cycle against a transaction-level model
module tb_wd_service_master;
    localparam int P = 10;
    localparam int M_IDLE = 0, M_TXN = 1, M_WAIT = 2, M_FAIL = 3;
    logic clk = 0, rst = 0, en = 0, kick = 0, clr = 0;
    logic [7:0] cfg_win = 0, cfg_rstlmt = 0;
    logic busy, cfg_done, fault;
    logic [1:0] fault_code;
    logic [7:0] kick_cnt;
    wd_service_master_if bus();
    wd_service_master #(.PERIOD(16'd10)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_win(cfg_win), .cfg_rstlmt(cfg_rstlmt),
        .kick(kick), .clr(clr), .bus(bus.master), .busy(busy), .cfg_done(cfg_done),
        .fault(fault), .fault_code(fault_code), .kick_cnt(kick_cnt)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;
    int m_mode = M_IDLE, m_pos = 0, m_job = 0, m_cnt = 0, m_code = 0, m_kc = 0;
    bit m_pend = 0, m_done = 0, m_fault = 0;
    logic [7:0] m_dat = 0;
    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic start(input int j);
        m_mode = M_TXN;
        m_pos  = 0;
        m_job  = j;
        if (j == 2) m_pend = 0;
    endtask
    // One clock edge of the reference behaviour, from the inputs held across that edge
    task automatic step();
        if (!rst) begin
            m_mode = M_IDLE; m_pos = 0; m_job = 0; m_cnt = 0; m_code = 0; m_kc = 0;
            m_pend = 0; m_done = 0; m_fault = 0; m_dat = 0;
        end else if (bus.wdfail) begin
            if (m_mode != M_FAIL) m_code = bus.flstat;
            m_mode = M_FAIL;
            m_fault = 1;
        end else begin
            case (m_mode)
                M_FAIL: if (clr) begin
                    m_mode = M_IDLE; m_fault = 0; m_code = 0; m_done = 0; m_pend = 0;
                end
                M_IDLE: if (en) begin
                    if (m_done) begin m_mode = M_WAIT; m_cnt = P; end
                    else start(0);
                end
                M_WAIT: begin
                    if (!en) m_mode = M_IDLE;
                    else if (kick || m_pend || m_cnt == 1) start(2);
                    else m_cnt--;
                end
                default: begin
                    if (kick) m_pend = 1;
                    if (m_pos == 0) m_dat = (m_job == 0) ? cfg_win : (m_job == 1) ? cfg_rstlmt : 8'hA5;
                    if (m_pos < 3) m_pos++;
                    else begin
                        if (m_job == 1) m_done = 1;
                        if (m_job == 2 && m_kc < 255) m_kc++;
                        if (!en) begin m_mode = M_IDLE; m_pend = 0; end
                        else if (m_job == 0) start(1);
                        else if (m_pend) start(2);
                        else begin m_mode = M_WAIT; m_cnt = P; end
                    end
                end
            endcase
        end
    endtask
    function automatic int exp_a();
        return (m_mode == M_TXN && m_pos == 2) ? ((m_job == 0) ? 0 : (m_job == 1) ? 1 : 3) : 0;
    endfunction
    function automatic int exp_d();
        if (m_mode != M_TXN) return 0;
        return (m_pos == 0) ? 8'h55 : (m_pos == 1) ? 8'hAA : (m_pos == 2) ? int'(m_dat) : 0;
    endfunction
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("abus", bus.abus, exp_a());
            check("dbus", bus.dbus, exp_d());
            check("busy", busy, int'(m_mode == M_TXN));
            check("cfg_done", cfg_done, m_done);
            check("fault", fault, m_fault);
            check("fault_code", fault_code, m_code);
            check("kick_cnt", kick_cnt, m_kc);
        end
    end
    task automatic tick();
        @(posedge clk);
        step();
        #1;
    endtask
    logic [1:0] sa [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [7:0] sd [8] = '{8'h55, 8'hAA, 8'h3C, 8'h00, 8'h55, 8'hAA, 8'h07, 8'h00};
    initial begin
        int nw, first, last, k;
        bus.wdfail = 0;
        bus.flstat = 0;
        tick();
        chk_on = 1;
        tick();
        check("rst_kick_cnt", kick_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1; en = 1; cfg_win = 8'h3C; cfg_rstlmt = 8'h07;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) cfg_win = 8'hFF;
            if (i == 5) cfg_rstlmt = 8'hEE;
            check("cfg_seq_abus", bus.abus, sa[i]);
            check("cfg_seq_dbus", bus.dbus, sd[i]);
        end
        check("cfg_done_early", cfg_done, 0);
        tick();
        check("cfg_done_c9", cfg_done, 1);
        nw = 0; first = -1; last = -1;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (bus.abus == 2'd3 && bus.dbus == 8'hA5) begin
                nw++;
                if (first < 0) first = t;
                last = t;
            end
        end
        check("srv_count", nw, 4);
        check("srv_spacing", last - first, 42);
        check("kick_cnt_60", kick_cnt, 4);
        kick = 1; tick(); kick = 0;
        check("kick_unlk0", bus.dbus, 8'h55);
        kick = 1; tick(); kick = 0;
        tick();
        kick = 1; tick(); kick = 0;
        tick();
        check("pend_unlk0", bus.dbus, 8'h55);
        repeat (4) tick();
        check("kick_cnt_plus2", kick_cnt, 6);
        repeat (9) tick();
        check("no_third_srv", kick_cnt, 6);
        k = 0;
        while (bus.dbus != 8'hAA && k < 40) begin tick(); k++; end
        check("wait_srv_unlk1", int'(k < 40), 1);
        bus.wdfail = 1; bus.flstat = 2'b10;
        tick();
        check("fail_fault", fault, 1);
        check("fail_code", fault_code, 2);
        check("fail_dbus", bus.dbus, 0);
        clr = 1; bus.flstat = 2'b01;
        tick();
        check("clr_ignored", fault, 1);
        check("code_held", fault_code, 2);
        bus.wdfail = 0; clr = 0;
        tick();
        clr = 1; tick(); clr = 0;
        check("clr_fault", fault, 0);
        check("clr_cfg_done", cfg_done, 0);
        check("clr_kick_cnt_kept", kick_cnt, 6);
        tick(); tick(); tick();
        check("cfg0_write_dbus", bus.dbus, 8'hFF);
        en = 0;
        tick(); tick();
        check("en_drop_idle", busy, 0);
        repeat (5) tick();
        check("en_drop_stays", busy, 0);
        en = 1;
        tick();
        check("restart_unlk0", bus.dbus, 8'h55);
        repeat (4000) begin
            en = en ? ($urandom_range(59) != 0) : ($urandom_range(9) == 0);
            kick = ($urandom_range(5) == 0);
            clr = ($urandom_range(7) == 0);
            bus.wdfail = ($urandom_range(99) == 0);
            bus.flstat = 2'($urandom);
            cfg_win = 8'($urandom);
            cfg_rstlmt = 8'($urandom);
            tick();
        end
        en = 1; kick = 0; bus.wdfail = 0; clr = 1;
        tick();
        clr = 0; kick = 1; k = 0;
        while (bus.abus != 2'd3 && k < 200) begin tick(); k++; end
        kick = 0;
        check("reach_srv_write", int'(k < 200), 1);
        rst = 0; bus.wdfail = 1;
        tick();
        check("rst_mid_kick_cnt", kick_cnt, 0);
        check("rst_mid_fault", fault, 0);
        check("rst_mid_dbus", bus.dbus, 0);
        rst = 1; bus.wdfail = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wd_service_master.md
# wd_service_master

Bus-master counterpart to the watchdog block: drives the watchdog's ABUS/DBUS write interface from the host side. After enable it unlocks and writes the window and reset-limit configuration, then issues periodic service writes at a programmable period. It also accepts on-demand kicks, and stops servicing and latches the failure code when the watchdog reports WDFAIL. It sits between the system controller and the watchdog top level.

## Interface

Parameters:
- KEY0, 8'h55, first unlock byte expected by the watchdog pattern comparator
- KEY1, 8'hAA, second unlock byte
- SRV_CODE, 8'hA5, data byte written to the service address
- PERIOD, 16'd100, cycles from end of one service transaction to start of the next

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-low
- EN  in  1  enable configuration and periodic servicing
- CFG_WIN  in  8  window-length byte, written to address 2'b00
- CFG_RSTLMT  in  8  reset-limit byte, written to address 2'b01
- KICK  in  1  one-cycle request for an immediate service write
- CLR  in  1  leave FAILED state
- WDFAIL  in  1  failure flag from watchdog
- FLSTAT  in  2  failure status from watchdog
- ABUS  out  2  address to watchdog
- DBUS  out  8  data to watchdog
- BUSY  out  1  transaction in progress
- CFG_DONE  out  1  both configuration writes completed
- FAULT  out  1  watchdog failure latched
- FAULT_CODE  out  2  FLSTAT captured at failure
- KICK_CNT  out  8  completed service writes, saturating

## Operation

- All outputs are registered.
- Transaction: 3 bus cycles followed by a 1-cycle gap.
  - UNLK0: ABUS=00, DBUS=KEY0.
  - UNLK1: ABUS=00, DBUS=KEY1.
  - WRITE: ABUS=addr, DBUS=data.
  - GAP: ABUS=00, DBUS=00.
- Idle bus value: ABUS=2'b00, DBUS=8'h00.
- States: IDLE, UNLK0, UNLK1, WRITE, GAP, WAIT, FAILED. A 2-bit sequence index selects the current job: CFG0 (addr 00, data CFG_WIN), CFG1 (addr 01, data CFG_RSTLMT), or SRV (addr 11, data SRV_CODE).
- IDLE:
  - EN=1 and CFG_DONE=0: start CFG0.
  - EN=1 and CFG_DONE=1: go to WAIT.
- State sequence: UNLK0→UNLK1→WRITE→GAP, unconditionally.
- At GAP exit:
  - After CFG0: start CFG1.
  - After CFG1: set CFG_DONE, go to WAIT.
  - After SRV: increment KICK_CNT (saturate at 255), go to WAIT.
  - In all cases: if EN=0, go to IDLE instead.
- WAIT: 16-bit counter loads PERIOD-1 on entry and decrements.
  - Start SRV at count 0, or on a KICK or pending kick, whichever comes first.
  - KICK in WAIT resets the counter.
- KICK while BUSY sets a single pending flag; further kicks are dropped. The flag clears when the SRV transaction starts.
- CFG_WIN/CFG_RSTLMT are sampled at the UNLK0 cycle of their transaction.
- EN falling mid-transaction: the current transaction completes, then IDLE. The pending kick is cleared.
- WDFAIL=1 in any state except reset:
  - Next cycle: FAILED, bus idle, FAULT=1, FAULT_CODE=FLSTAT sampled that cycle.
  - A partial transaction is abandoned.
- FAILED:
  - No bus activity.
  - CLR=1 with WDFAIL=0: go to IDLE, clear FAULT, FAULT_CODE, CFG_DONE and the pending flag, so the next enable reconfigures.
  - CLR with WDFAIL=1 is ignored.
  - KICK_CNT is preserved.
- BUSY=1 in UNLK0, UNLK1, WRITE and GAP.

## Timing

- Reset (RST=0 at edge): state IDLE, ABUS=00, DBUS=00, BUSY=0, CFG_DONE=0, FAULT=0, FAULT_CODE=00, KICK_CNT=0, pending=0, counter=0. Reset overrides WDFAIL and all other inputs.
- Sampling EN=1 in IDLE at edge N puts UNLK0 on the bus at cycle N+1.
- CFG0 occupies cycles N+1..N+4 and CFG1 occupies N+5..N+8. CFG_DONE rises at N+9, the first WAIT cycle.
- Service spacing: the first SRV UNLK0 occurs PERIOD cycles after WAIT entry. Consecutive SRV UNLK0 cycles are PERIOD+4 cycles apart when there are no kicks.
- KICK sampled in WAIT at edge M puts UNLK0 at M+1.
- KICK during a transaction starts SRV UNLK0 in the cycle after GAP.
- WDFAIL sampled at edge F: FAULT=1 and the bus is idle from F+1.
- KICK_CNT and CFG_DONE update on the GAP→next-state edge.
- PERIOD=1 is legal: WAIT lasts one cycle.

## Test plan

- Reset, then EN=1, CFG_WIN=8'h3C, CFG_RSTLMT=8'h07 → bus sequence (00,55)(00,AA)(00,3C)(00,00)(00,55)(00,AA)(01,07)(00,00); CFG_DONE=1 at cycle 9.
- PERIOD=10, no kicks, run 60 cycles after CFG_DONE → SRV writes (11,A5) with UNLK0 cycles 14 apart; KICK_CNT=4.
- KICK pulsed at WAIT count 5, then KICK pulsed twice during the resulting SRV transaction → immediate SRV, then exactly one extra SRV right after GAP; KICK_CNT +2.
- WDFAIL=1 with FLSTAT=2'b10 during an SRV UNLK1 cycle → WRITE never driven; FAULT=1, FAULT_CODE=10, bus 00/00 from the next cycle. CLR while WDFAIL=1 has no effect. CLR after WDFAIL=0 → IDLE, CFG_DONE=0, reconfiguration replays.
- EN dropped during a CFG0 WRITE cycle → CFG0 completes, GAP, IDLE; CFG1 not issued. EN re-raised → restarts at CFG0.
- RST=0 asserted mid-SRV with WDFAIL=1 → all outputs at reset values on the next cycle; KICK_CNT=0.
